traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
Passive protocol checker on the 2-bit light bus driven by the traffic light controller. It samples light every clock and tracks the expected RED->GREEN->YELLOW->RED sequence. It measures the dwell time of each phase and flags illegal codes, out-of-order transitions, short phases and stuck phases. It also counts completed light cycles. It sits beside the controller in the intersection subsystem and feeds a status/debug register bank.

Parameters:
RED_MIN, 3, minimum legal RED dwell in cycles (1..2^CNT_W-1)
GREEN_MIN, 3, minimum legal GREEN dwell in cycles
YELLOW_MIN, 1, minimum legal YELLOW dwell in cycles
MAX_DWELL, 8, maximum legal dwell of any phase before stuck error (must be >= every *_MIN)
CNT_W, 8, dwell counter width
CYC_W, 16, completed-cycle counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
light  in  2  observed light code: 00 RED, 01 GREEN, 10 YELLOW, 11 invalid
phase  out  2  tracked phase (same encoding; 11 = unsynchronised)
dwell  out  CNT_W  cycles the current phase has been observed, saturating
cycle_count  out  CYC_W  completed YELLOW->RED transitions, wraps modulo 2^CYC_W
code_err  out  1  one-cycle pulse: light==11 sampled
seq_err  out  1  one-cycle pulse: illegal phase change
short_err  out  1  one-cycle pulse: legal change before *_MIN reached
stuck_err  out  1  one-cycle pulse: dwell exceeded MAX_DWELL
err_sticky  out  1  OR of all error pulses since reset

Behaviour:
- All outputs are registered. light is sampled at posedge k, and the results are visible after posedge k (one-cycle latency).
- Reset (reset==0 at posedge): phase=11 (SYNC), dwell=0, cycle_count=0, all pulses=0, err_sticky=0. Reset asserted mid-operation discards all history, with the same values. No error is raised on the first sample after reset.
- FSM states: SYNC, RED, GREEN, YELLOW.
- SYNC: a valid code enters the matching state with dwell=1 and no error. light==11 raises code_err and stays in SYNC.
- Tracked state S, light equals S: dwell += 1, saturating at 2^CNT_W-1. stuck_err pulses exactly once, on the sample where dwell becomes MAX_DWELL+1. No repeat pulse while the phase stays stuck.
- Tracked state S, light is the legal successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED):
  - short_err if the old dwell < S_MIN.
  - Move to the successor with dwell=1.
  - YELLOW->RED increments cycle_count, even if short_err fires on the same sample.
- Tracked state S, light is another valid non-successor (e.g. RED->YELLOW, GREEN->RED): seq_err pulses. The FSM resyncs to the observed phase with dwell=1 and cycle_count unchanged.
- light==11 in any tracked state: code_err pulses, phase becomes SYNC, dwell=0.
- Only one error class is possible per sample, except that code_err and stuck_err cannot coexist. Pulses are high for exactly one cycle per event.
- err_sticky sets on any pulse and clears only on reset.
- cycle_count wraps from 2^CYC_W-1 to 0 silently.

Decomposition:
- traffic_light_pkg holds the light encoding constants RED/GREEN/YELLOW/INVALID and the successor function. The controller and this monitor share it.
- Optional sub-module dwell_counter: saturating counter with load-1, clear and increment. The rest stays flat in one FSM.

Test Plan:
1. Reset low 2 cycles, then light RED x3, GREEN x3, YELLOW x1, RED -> no errors, cycle_count=1, phase=00, dwell=1 after the final RED sample.
2. After sync, RED x2 then GREEN -> short_err pulses 1 cycle, phase=01, dwell=1, err_sticky=1.
3. After sync, RED x3 then YELLOW -> seq_err pulse, phase=10, cycle_count unchanged (0).
4. GREEN held 12 cycles -> stuck_err pulses once on the 9th sample, dwell reads 12 at the end, no further pulses.
5. light=11 mid-GREEN -> code_err pulse, phase=11, dwell=0. Next sample RED -> phase=00, no error.
6. Reset asserted for 1 cycle mid-YELLOW with err_sticky=1 and cycle_count=5 -> all outputs zero and phase=11. First post-reset sample YELLOW -> phase=10, no error.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Light bus encoding and phase ordering shared by the traffic light controller and its monitor.
package traffic_light_pkg;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] GREEN   = 2'b01;
  localparam logic [1:0] YELLOW  = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  // Monitor tracking state; the encoding matches the light codes so it can drive phase directly.
  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_SYNC   = 2'b11
  } state_t;

  function automatic logic [1:0] successor(input logic [1:0] code);
    case (code)
      RED:     successor = GREEN;
      GREEN:   successor = YELLOW;
      YELLOW:  successor = RED;
      default: successor = INVALID;
    endcase
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter: clear to 0, load to 1 on phase entry, or increment while the phase holds.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the RED->GREEN->YELLOW light sequence: tracks phase and dwell, flags protocol errors, counts cycles.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_MIN    = 3,
  parameter int GREEN_MIN  = 3,
  parameter int YELLOW_MIN = 1,
  parameter int MAX_DWELL  = 8,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       light,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CYC_W-1:0] cycle_count,
  output logic             code_err,
  output logic             seq_err,
  output logic             short_err,
  output logic             stuck_err,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] RED_MIN_C    = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] GREEN_MIN_C  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YELLOW_MIN_C = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] MAX_C        = CNT_W'(MAX_DWELL);

  // Classification of the current sample relative to the tracked phase.
  typedef enum logic [2:0] {
    EV_CODE,
    EV_SYNC,
    EV_HOLD,
    EV_ADVANCE,
    EV_JUMP
  } event_t;

  state_t state;
  event_t ev;
  logic   cnt_clr;
  logic   cnt_load1;
  logic   cnt_inc;

  function automatic logic [CNT_W-1:0] phase_min(input state_t s);
    case (s)
      ST_RED:    phase_min = RED_MIN_C;
      ST_GREEN:  phase_min = GREEN_MIN_C;
      ST_YELLOW: phase_min = YELLOW_MIN_C;
      default:   phase_min = '0;
    endcase
  endfunction

  always_comb begin
    ev = EV_JUMP;
    if (light == INVALID) begin
      ev = EV_CODE;
    end else if (state == ST_SYNC) begin
      ev = EV_SYNC;
    end else if (light == 2'(state)) begin
      ev = EV_HOLD;
    end else if (light == successor(2'(state))) begin
      ev = EV_ADVANCE;
    end
  end

  always_comb begin
    cnt_clr   = (ev == EV_CODE);
    cnt_inc   = (ev == EV_HOLD);
    cnt_load1 = (ev == EV_SYNC) || (ev == EV_ADVANCE) || (ev == EV_JUMP);
  end

  dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .load1(cnt_load1),
    .inc  (cnt_inc),
    .count(dwell)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_SYNC;
      cycle_count <= '0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      short_err   <= 1'b0;
      stuck_err   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      short_err <= 1'b0;
      stuck_err <= 1'b0;
      case (ev)
        EV_CODE: begin
          code_err   <= 1'b1;
          err_sticky <= 1'b1;
          state      <= ST_SYNC;
        end
        EV_SYNC: begin
          state <= state_t'(light);
        end
        EV_HOLD: begin
          // Old dwell equal to MAX_DWELL means this sample is the first one over the limit.
          if (dwell == MAX_C && dwell != '1) begin
            stuck_err  <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
        EV_ADVANCE: begin
          if (dwell < phase_min(state)) begin
            short_err  <= 1'b1;
            err_sticky <= 1'b1;
          end
          if (state == ST_YELLOW) begin
            cycle_count <= cycle_count + CYC_W'(1);
          end
          state <= state_t'(light);
        end
        default: begin
          seq_err    <= 1'b1;
          err_sticky <= 1'b1;
          state      <= state_t'(light);
        end
      endcase
    end
  end

  assign phase = 2'(state);

endmodule
